// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the in-order integer pipeline. Detects
//   load-use RAW hazards, holds the core for multi-cycle multiplies and data
//   cache misses, and flushes the younger stages on taken branches.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_RUN      | normal issue; hazard / branch / miss / mul-issue detection
//   ST_MUL_WAIT | multiply occupying exe; fetch and core held, down-counting
//   ST_MEM_WAIT | data-cache refill outstanding; held until dcache_ready_i
//   (enc 3)     | unreachable; behaves as ST_RUN and returns to it
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   dec_*                     decode-stage instruction info
//   exe_*                     exe-stage destination / load / branch info
//   dcache_miss_i/ready_i     mem-stage miss pulse and refill-complete
//   stall_fetch_o/core_o      hold PC+fetch/dec latch / hold dec/exe onwards
//   kill_fetch_dec_o/dec_exe_o clear the respective pipeline latch
//   state_o                   current FSM state (0 RUN, 1 MUL_WAIT, 2 MEM_WAIT)
//   stall_cycles_o            saturating count of cycles with stall_fetch_o high

module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dec_valid_i,
    input  logic [4:0]        dec_rs1_addr_i,
    input  logic [4:0]        dec_rs2_addr_i,
    input  logic              dec_uses_rs1_i,
    input  logic              dec_uses_rs2_i,
    input  logic              dec_is_mul_i,
    input  logic [4:0]        exe_write_addr_i,
    input  logic              exe_int_write_enable_i,
    input  logic              exe_is_load_i,
    input  logic              exe_branch_taken_i,
    input  logic              dcache_miss_i,
    input  logic              dcache_ready_i,
    output logic              stall_fetch_o,
    output logic              stall_core_o,
    output logic              kill_fetch_dec_o,
    output logic              kill_dec_exe_o,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        mul_cnt_q;
    logic [3:0]        mul_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q;
    logic              load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = dec_valid_i && exe_is_load_i && exe_int_write_enable_i &&
                      (exe_write_addr_i != 5'd0) &&
                      ((dec_uses_rs1_i && (dec_rs1_addr_i == exe_write_addr_i)) ||
                       (dec_uses_rs2_i && (dec_rs2_addr_i == exe_write_addr_i)));

    always_comb begin
        state_d          = state_q;
        mul_cnt_d        = mul_cnt_q;
        stall_fetch_o    = 1'b0;
        stall_core_o     = 1'b0;
        kill_fetch_dec_o = 1'b0;
        kill_dec_exe_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_MUL_WAIT: begin
                    stall_fetch_o = 1'b1;
                    stall_core_o  = 1'b1;
                    if (dcache_miss_i) begin
                        // The stall keeps the mul result in place while the refill runs.
                        state_d   = ST_MEM_WAIT;
                        mul_cnt_d = 4'd0;
                    end else begin
                        mul_cnt_d = mul_cnt_q - 4'd1;
                        if (mul_cnt_q == 4'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    stall_fetch_o = 1'b1;
                    stall_core_o  = 1'b1;
                    if (dcache_ready_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // ST_RUN and the unused encoding share this path.
                    state_d = ST_RUN;
                    if (dcache_miss_i) begin
                        stall_fetch_o = 1'b1;
                        stall_core_o  = 1'b1;
                        state_d       = ST_MEM_WAIT;
                    end else if (exe_branch_taken_i) begin
                        // Decode holds a wrong-path instruction: no hazard, no mul issue.
                        kill_fetch_dec_o = 1'b1;
                        kill_dec_exe_o   = 1'b1;
                    end else if (load_use) begin
                        stall_fetch_o  = 1'b1;
                        kill_dec_exe_o = 1'b1;
                    end else if (dec_valid_i && dec_is_mul_i) begin
                        state_d   = ST_MUL_WAIT;
                        mul_cnt_d = MUL_LOAD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            mul_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (stall_fetch_o && (stall_cnt_q != {PERF_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign state_o        = rst_i ? 2'd0 : state_q;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. A second instance with a
// 3-bit performance counter exercises saturation without long runs.

module tb_pipeline_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dec_valid_i;
    logic [4:0]  dec_rs1_addr_i;
    logic [4:0]  dec_rs2_addr_i;
    logic        dec_uses_rs1_i;
    logic        dec_uses_rs2_i;
    logic        dec_is_mul_i;
    logic [4:0]  exe_write_addr_i;
    logic        exe_int_write_enable_i;
    logic        exe_is_load_i;
    logic        exe_branch_taken_i;
    logic        dcache_miss_i;
    logic        dcache_ready_i;

    logic        stall_fetch_o, stall_core_o, kill_fetch_dec_o, kill_dec_exe_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles_o;

    logic        n_stall_fetch, n_stall_core, n_kill_fd, n_kill_de;
    logic [1:0]  n_state;
    logic [2:0]  n_stall_cycles;

    logic [3:0]  ctl;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] s0;

    assign ctl = {stall_fetch_o, stall_core_o, kill_fetch_dec_o, kill_dec_exe_o};

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .PERF_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_rs1_addr_i(dec_rs1_addr_i),
        .dec_rs2_addr_i(dec_rs2_addr_i), .dec_uses_rs1_i(dec_uses_rs1_i),
        .dec_uses_rs2_i(dec_uses_rs2_i), .dec_is_mul_i(dec_is_mul_i),
        .exe_write_addr_i(exe_write_addr_i),
        .exe_int_write_enable_i(exe_int_write_enable_i),
        .exe_is_load_i(exe_is_load_i), .exe_branch_taken_i(exe_branch_taken_i),
        .dcache_miss_i(dcache_miss_i), .dcache_ready_i(dcache_ready_i),
        .stall_fetch_o(stall_fetch_o), .stall_core_o(stall_core_o),
        .kill_fetch_dec_o(kill_fetch_dec_o), .kill_dec_exe_o(kill_dec_exe_o),
        .state_o(state_o), .stall_cycles_o(stall_cycles_o)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(4), .PERF_W(3)) dut_narrow (
        .clk_i(clk_i), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_rs1_addr_i(dec_rs1_addr_i),
        .dec_rs2_addr_i(dec_rs2_addr_i), .dec_uses_rs1_i(dec_uses_rs1_i),
        .dec_uses_rs2_i(dec_uses_rs2_i), .dec_is_mul_i(dec_is_mul_i),
        .exe_write_addr_i(exe_write_addr_i),
        .exe_int_write_enable_i(exe_int_write_enable_i),
        .exe_is_load_i(exe_is_load_i), .exe_branch_taken_i(exe_branch_taken_i),
        .dcache_miss_i(dcache_miss_i), .dcache_ready_i(dcache_ready_i),
        .stall_fetch_o(n_stall_fetch), .stall_core_o(n_stall_core),
        .kill_fetch_dec_o(n_kill_fd), .kill_dec_exe_o(n_kill_de),
        .state_o(n_state), .stall_cycles_o(n_stall_cycles)
    );

    task automatic idle_inputs();
        dec_valid_i = 0; dec_rs1_addr_i = 0; dec_rs2_addr_i = 0;
        dec_uses_rs1_i = 0; dec_uses_rs2_i = 0; dec_is_mul_i = 0;
        exe_write_addr_i = 0; exe_int_write_enable_i = 0; exe_is_load_i = 0;
        exe_branch_taken_i = 0; dcache_miss_i = 0; dcache_ready_i = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        exe_is_load_i = 1; exe_int_write_enable_i = 1; exe_write_addr_i = rd;
        dec_valid_i = 1; dec_uses_rs1_i = 1; dec_rs1_addr_i = rd;
        dec_uses_rs2_i = 1; dec_rs2_addr_i = 5'd1;
    endtask

    task automatic test_reset();
        rst_i = 1; idle_inputs();
        dcache_miss_i = 1; exe_branch_taken_i = 1;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl got %b want 0000", ctl); end
        n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
        step(); step();
        idle_inputs(); rst_i = 0;
        @(negedge clk_i);
        n_cmp++; if (stall_cycles_o !== 32'd0) begin n_fail++; $display("FAIL reset_perf got %0d want 0", stall_cycles_o); end
        n_cmp++; if ({ctl, state_o} !== 6'd0) begin n_fail++; $display("FAIL reset_idle got %b want 000000", {ctl, state_o}); end
        step();
    endtask

    task automatic test_load_use();
        s0 = stall_cycles_o;
        set_load_use(5'd5);
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b1001) begin n_fail++; $display("FAIL load_use_rs1 got %b want 1001", ctl); end
        step();
        exe_is_load_i = 0; exe_int_write_enable_i = 0; exe_write_addr_i = 0;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL load_use_after got %b want 0000", ctl); end
        n_cmp++; if (stall_cycles_o !== s0 + 1) begin n_fail++; $display("FAIL load_use_perf got %0d want %0d", stall_cycles_o, s0 + 1); end
        step();
        idle_inputs();
        exe_is_load_i = 1; exe_int_write_enable_i = 1; exe_write_addr_i = 5'd9;
        dec_valid_i = 1; dec_uses_rs2_i = 1; dec_rs2_addr_i = 5'd9; dec_rs1_addr_i = 5'd2; dec_uses_rs1_i = 1;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b1001) begin n_fail++; $display("FAIL load_use_rs2 got %b want 1001", ctl); end
        step(); idle_inputs();
    endtask

    task automatic test_no_hazard();
        set_load_use(5'd0);
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL no_haz_x0 got %b want 0000", ctl); end
        step();
        set_load_use(5'd5); dec_rs1_addr_i = 5'd3; dec_rs2_addr_i = 5'd5; dec_uses_rs2_i = 0;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL no_haz_unused_rs2 got %b want 0000", ctl); end
        step();
        set_load_use(5'd7); dec_valid_i = 0;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL no_haz_dec_invalid got %b want 0000", ctl); end
        step();
        set_load_use(5'd7); exe_int_write_enable_i = 0;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL no_haz_no_we got %b want 0000", ctl); end
        step();
        set_load_use(5'd7); exe_is_load_i = 0;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b0000) begin n_fail++; $display("FAIL no_haz_not_load got %b want 0000", ctl); end
        step(); idle_inputs();
    endtask

    task automatic test_mul();
        s0 = stall_cycles_o;
        dec_valid_i = 1; dec_is_mul_i = 1;
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b0000_00) begin n_fail++; $display("FAIL mul_issue got %b want 000000", {ctl, state_o}); end
        step(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            exe_branch_taken_i = (i == 1);
            @(negedge clk_i);
            n_cmp++; if ({ctl, state_o} !== 6'b1100_01) begin n_fail++; $display("FAIL mul_wait_%0d got %b want 110001", i, {ctl, state_o}); end
            step();
        end
        idle_inputs();
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b0000_00) begin n_fail++; $display("FAIL mul_done got %b want 000000", {ctl, state_o}); end
        n_cmp++; if (stall_cycles_o !== s0 + 3) begin n_fail++; $display("FAIL mul_perf got %0d want %0d", stall_cycles_o, s0 + 3); end
        step();
    endtask

    task automatic test_miss();
        s0 = stall_cycles_o;
        dcache_miss_i = 1;
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b1100_00) begin n_fail++; $display("FAIL miss_first got %b want 110000", {ctl, state_o}); end
        step(); idle_inputs();
        for (int i = 0; i < 5; i++) begin
            dcache_ready_i = (i == 4);
            @(negedge clk_i);
            n_cmp++; if ({ctl, state_o} !== 6'b1100_10) begin n_fail++; $display("FAIL miss_wait_%0d got %b want 110010", i, {ctl, state_o}); end
            step();
        end
        idle_inputs();
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b0000_00) begin n_fail++; $display("FAIL miss_done got %b want 000000", {ctl, state_o}); end
        n_cmp++; if (stall_cycles_o !== s0 + 6) begin n_fail++; $display("FAIL miss_perf got %0d want %0d", stall_cycles_o, s0 + 6); end
        // Ready and a new miss in the same MEM_WAIT cycle: ready wins.
        dcache_miss_i = 1; step();
        dcache_ready_i = 1; dcache_miss_i = 1; step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL miss_ready_same got %0d want 0", state_o); end
        step();
    endtask

    task automatic test_priority();
        set_load_use(5'd5); exe_branch_taken_i = 1;
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b0011_00) begin n_fail++; $display("FAIL prio_branch_lu got %b want 001100", {ctl, state_o}); end
        step(); idle_inputs();
        set_load_use(5'd5); exe_branch_taken_i = 1; dcache_miss_i = 1;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL prio_miss_branch got %b want 1100", ctl); end
        step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL prio_miss_state got %0d want 2", state_o); end
        dcache_ready_i = 1; step(); idle_inputs();
        dec_valid_i = 1; dec_is_mul_i = 1; exe_branch_taken_i = 1; step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL prio_branch_mul got %0d want 0", state_o); end
        set_load_use(5'd4); dec_is_mul_i = 1;
        @(negedge clk_i);
        n_cmp++; if (ctl !== 4'b1001) begin n_fail++; $display("FAIL prio_lu_mul_ctl got %b want 1001", ctl); end
        step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL prio_lu_mul_state got %0d want 0", state_o); end
        step();
    endtask

    task automatic test_mul_miss();
        dec_valid_i = 1; dec_is_mul_i = 1; step(); idle_inputs();
        dcache_miss_i = 1;
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b1100_01) begin n_fail++; $display("FAIL mul_miss_ctl got %b want 110001", {ctl, state_o}); end
        step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL mul_miss_state got %0d want 2", state_o); end
        dcache_ready_i = 1; step(); idle_inputs();
        // A fresh multiply must again hold for exactly three cycles.
        s0 = stall_cycles_o;
        dec_valid_i = 1; dec_is_mul_i = 1; step(); idle_inputs();
        step(); step(); step();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd0 || stall_cycles_o !== s0 + 3) begin n_fail++; $display("FAIL mul_reissue got state %0d perf %0d want 0 %0d", state_o, stall_cycles_o, s0 + 3); end
        step();
    endtask

    task automatic test_back_to_back();
        // Two multiplies in a row: second issues the cycle RUN resumes.
        dec_valid_i = 1; dec_is_mul_i = 1; step();
        step(); step(); step();
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'b0000_00) begin n_fail++; $display("FAIL b2b_gap got %b want 000000", {ctl, state_o}); end
        step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL b2b_second got %0d want 1", state_o); end
        step(); step(); step();
    endtask

    task automatic test_reset_mid_mul();
        dec_valid_i = 1; dec_is_mul_i = 1; step(); idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL rst_mul_pre got %0d want 1", state_o); end
        rst_i = 1;
        #1;
        n_cmp++; if ({ctl, state_o} !== 6'd0) begin n_fail++; $display("FAIL rst_mul_during got %b want 000000", {ctl, state_o}); end
        step(); rst_i = 0;
        @(negedge clk_i);
        n_cmp++; if ({ctl, state_o} !== 6'd0) begin n_fail++; $display("FAIL rst_mul_after got %b want 000000", {ctl, state_o}); end
        n_cmp++; if (stall_cycles_o !== 32'd0) begin n_fail++; $display("FAIL rst_mul_perf got %0d want 0", stall_cycles_o); end
        step();
    endtask

    task automatic test_saturation();
        dcache_miss_i = 1; step(); idle_inputs();
        for (int i = 0; i < 9; i++) begin
            dcache_ready_i = (i == 8);
            step();
        end
        idle_inputs();
        @(negedge clk_i);
        n_cmp++; if (n_stall_cycles !== 3'd7) begin n_fail++; $display("FAIL sat_narrow got %0d want 7", n_stall_cycles); end
        n_cmp++; if (stall_cycles_o !== 32'd10) begin n_fail++; $display("FAIL sat_wide got %0d want 10", stall_cycles_o); end
        n_cmp++; if (n_state !== 2'd0) begin n_fail++; $display("FAIL sat_narrow_state got %0d want 0", n_state); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mul();
        test_miss();
        test_priority();
        test_mul_miss();
        test_back_to_back();
        test_reset_mid_mul();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
